// File: rtl/tetron_pkg.sv
// Shared definitions for the tetron rotator: piece codes, kick order and the
// per-piece shape table with its lookup function.
package tetron_pkg;

  localparam int OFF_W_DEF = 5;
  localparam int MAX_KICKS = 5;

  typedef enum logic [2:0] {
    PC_I = 3'd0, PC_O = 3'd1, PC_T = 3'd2, PC_S = 3'd3,
    PC_Z = 3'd4, PC_J = 3'd5, PC_L = 3'd6, PC_X = 3'd7
  } piece_e;

  localparam int KICK_ORDER [MAX_KICKS] = '{0, 1, -1, 2, -2};

  // [piece][rot] -> {v2,h2, v3,h3, v4,h4}; blk1 is the pivot at (0,0).
  localparam int SHAPE_TBL [7][4][6] = '{
    '{'{ 0,-1,  0, 1,  0, 2}, '{-1, 0,  1, 0,  2, 0}, '{ 0, 1,  0,-1,  0,-2}, '{ 1, 0, -1, 0, -2, 0}},
    '{'{ 0, 1,  1, 0,  1, 1}, '{ 0, 1,  1, 0,  1, 1}, '{ 0, 1,  1, 0,  1, 1}, '{ 0, 1,  1, 0,  1, 1}},
    '{'{ 0, 1,  0,-1,  1, 0}, '{ 1, 0, -1, 0,  0, 1}, '{ 0, 1,  0,-1, -1, 0}, '{ 1, 0, -1, 0,  0,-1}},
    '{'{ 0, 1,  1, 0,  1,-1}, '{-1, 0,  0, 1,  1, 1}, '{ 0,-1, -1, 0, -1, 1}, '{ 1, 0,  0,-1, -1,-1}},
    '{'{ 0,-1,  1, 0,  1, 1}, '{ 1, 0,  0, 1, -1, 1}, '{ 0, 1, -1, 0, -1,-1}, '{-1, 0,  0,-1,  1,-1}},
    '{'{ 0,-1,  0, 1, -1,-1}, '{ 1, 0, -1, 0,  1,-1}, '{ 0, 1,  0,-1,  1, 1}, '{-1, 0,  1, 0, -1, 1}},
    '{'{ 0,-1,  0, 1, -1, 1}, '{ 1, 0, -1, 0, -1,-1}, '{ 0, 1,  0,-1,  1,-1}, '{-1, 0,  1, 0,  1, 1}}
  };

  // Offset of block blk (0..3) for piece/rot; horiz selects h over v. Code 7 aliases O.
  function automatic int shape_off(logic [2:0] piece, logic [1:0] rot, int blk, logic horiz);
    int p;
    p = (piece == PC_X) ? int'(PC_O) : int'(piece);
    if (blk == 0) return 0;
    return SHAPE_TBL[p][rot][2*(blk-1) + int'(horiz)];
  endfunction

endpackage

// File: rtl/tetron_rotator_if.sv
// Collision-checker query/response handshake between the rotator and the playfield.
interface tetron_rotator_if import tetron_pkg::*; #(
  parameter int OFF_W = OFF_W_DEF
);
  logic             chk_valid;
  logic             chk_ready;
  logic [1:0]       chk_rot;
  logic [OFF_W-1:0] chk_kick;
  logic             chk_resp_valid;
  logic             chk_collide;

  modport master (output chk_valid, chk_rot, chk_kick,
                  input  chk_ready, chk_resp_valid, chk_collide);
  modport slave  (input  chk_valid, chk_rot, chk_kick,
                  output chk_ready, chk_resp_valid, chk_collide);
endinterface

// File: rtl/tetron_shape_rom.sv
// Combinational (piece, rotation) -> four (v,h) block offsets.
module tetron_shape_rom import tetron_pkg::*; #(
  parameter int OFF_W = OFF_W_DEF
) (
  input  logic [2:0]            piece,
  input  logic [1:0]            rot,
  output logic [3:0][OFF_W-1:0] voff,
  output logic [3:0][OFF_W-1:0] hoff
);
  for (genvar b = 0; b < 4; b++) begin : g_blk
    assign voff[b] = OFF_W'(shape_off(piece, rot, b, 1'b0));
    assign hoff[b] = OFF_W'(shape_off(piece, rot, b, 1'b1));
  end
endmodule

// File: rtl/tetron_rotator.sv
// Rotation state + CW/CCW request FSM for all seven tetrons; candidates go to the
// collision checker in kick order. Wall kicks beyond h=0 need TETRON_WALL_KICK_EN.
module tetron_rotator import tetron_pkg::*; #(
  parameter int OFF_W     = OFF_W_DEF,
  parameter int NUM_KICKS = MAX_KICKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             load,
  input  logic [2:0]       piece_type,
  input  logic             rot_req,
  input  logic             rot_dir,
  output logic             rot_busy,
  output logic             rot_done,
  output logic             rot_ok,
  output logic [1:0]       rotation,
  output logic [OFF_W-1:0] kick_hoffset,
  output logic [OFF_W-1:0] blk1_voffset, blk1_hoffset,
  output logic [OFF_W-1:0] blk2_voffset, blk2_hoffset,
  output logic [OFF_W-1:0] blk3_voffset, blk3_hoffset,
  output logic [OFF_W-1:0] blk4_voffset, blk4_hoffset,
  tetron_rotator_if.master chk
);
  localparam int KICKS_CFG = (NUM_KICKS < 1) ? 1 : (NUM_KICKS > MAX_KICKS) ? MAX_KICKS : NUM_KICKS;
  localparam int KIW       = $clog2(KICKS_CFG + 1);
`ifdef TETRON_WALL_KICK_EN
  localparam int NK = KICKS_CFG;
`else
  localparam int NK = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_QUERY, S_WAIT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [2:0]            piece_q, piece_d;
  logic [1:0]            rot_q, rot_d, cand_q, cand_d;
  logic [OFF_W-1:0]      kick_q, kick_d, cand_kick;
  logic [KIW-1:0]        kidx_q, kidx_d;
  logic                  ok_q, ok_d;
  logic [3:0][OFF_W-1:0] rom_v, rom_h, blk_v_q, blk_h_q;

  assign cand_kick = kick_q + OFF_W'(KICK_ORDER[kidx_q]);

  always_comb begin
    state_d = state_q;
    piece_d = piece_q;
    rot_d   = rot_q;
    cand_d  = cand_q;
    kick_d  = kick_q;
    kidx_d  = kidx_q;
    ok_d    = ok_q;
    if (!active) begin
      state_d = S_IDLE;
    end else if (load) begin
      state_d = S_IDLE;
      piece_d = piece_type;
      rot_d   = '0;
      kick_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: if (rot_req) begin
          cand_d = rot_dir ? rot_q - 2'd1 : rot_q + 2'd1;
          kidx_d = '0;
          // O looks the same in every rotation, so no collision query is needed.
          if (piece_q == PC_O || piece_q == PC_X) begin
            rot_d   = cand_d;
            ok_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_QUERY;
          end
        end
        S_QUERY: if (chk.chk_ready) state_d = S_WAIT;
        S_WAIT: if (chk.chk_resp_valid) begin
          if (!chk.chk_collide) begin
            rot_d   = cand_q;
            kick_d  = cand_kick;
            ok_d    = 1'b1;
            state_d = S_DONE;
          end else if (int'(kidx_q) < NK - 1) begin
            kidx_d  = kidx_q + KIW'(1);
            state_d = S_QUERY;
          end else begin
            ok_d    = 1'b0;
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Shapes are looked up for the next committed state so offsets land with rotation.
  tetron_shape_rom #(.OFF_W(OFF_W)) u_rom (
    .piece (piece_d),
    .rot   (rot_d),
    .voff  (rom_v),
    .hoff  (rom_h)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      piece_q <= PC_O;
      rot_q   <= '0;
      cand_q  <= '0;
      kick_q  <= '0;
      kidx_q  <= '0;
      ok_q    <= 1'b0;
      blk_v_q <= '0;
      blk_h_q <= '0;
    end else begin
      state_q <= state_d;
      piece_q <= piece_d;
      rot_q   <= rot_d;
      cand_q  <= cand_d;
      kick_q  <= kick_d;
      kidx_q  <= kidx_d;
      ok_q    <= ok_d;
      if (!active) begin
        blk_v_q <= '0;
        blk_h_q <= '0;
      end else begin
        blk_v_q <= rom_v;
        for (int b = 0; b < 4; b++) blk_h_q[b] <= rom_h[b] + kick_d;
      end
    end
  end

  assign rot_busy      = (state_q != S_IDLE);
  assign rot_done      = (state_q == S_DONE);
  assign rot_ok        = rot_done && ok_q;
  assign rotation      = rot_q;
  assign kick_hoffset  = kick_q;
  assign chk.chk_valid = (state_q == S_QUERY);
  assign chk.chk_rot   = chk.chk_valid ? cand_q : 2'd0;
  assign chk.chk_kick  = chk.chk_valid ? cand_kick : '0;

  assign blk1_voffset = blk_v_q[0];
  assign blk1_hoffset = blk_h_q[0];
  assign blk2_voffset = blk_v_q[1];
  assign blk2_hoffset = blk_h_q[1];
  assign blk3_voffset = blk_v_q[2];
  assign blk3_hoffset = blk_h_q[2];
  assign blk4_voffset = blk_v_q[3];
  assign blk4_hoffset = blk_h_q[3];
endmodule

// File: tb/tb_tetron_rotator.sv
// Directed bench for tetron_rotator: a transaction-level model (candidate-kick queue,
// T shape table) is compared against every output each cycle, plus literal pin checks.
module tb_tetron_rotator;
`ifdef TETRON_WALL_KICK_EN
  localparam int NK = 5;
`else
  localparam int NK = 1;
`endif
  localparam int KO [5] = '{0, 1, -1, 2, -2};
  // T piece (v,h) per rotation, blocks 1..4
  localparam int T_V [4][4] = '{'{0,0,0,1}, '{0,1,-1,0}, '{0,0,0,-1}, '{0,1,-1,0}};
  localparam int T_H [4][4] = '{'{0,1,-1,0}, '{0,0,0,1}, '{0,1,-1,0}, '{0,0,0,-1}};

  logic clk, rst, active, load, rot_req, rot_dir;
  logic [2:0] piece_type;
  logic busy, done, ok;
  logic [1:0] rotation;
  logic [4:0] kick;
  logic [4:0] bv [4];
  logic [4:0] bh [4];

  tetron_rotator_if #(.OFF_W(5)) cif ();

  tetron_rotator #(.OFF_W(5), .NUM_KICKS(5)) dut (
    .clk(clk), .rst(rst), .active(active), .load(load), .piece_type(piece_type),
    .rot_req(rot_req), .rot_dir(rot_dir), .rot_busy(busy), .rot_done(done), .rot_ok(ok),
    .rotation(rotation), .kick_hoffset(kick),
    .blk1_voffset(bv[0]), .blk1_hoffset(bh[0]), .blk2_voffset(bv[1]), .blk2_hoffset(bh[1]),
    .blk3_voffset(bv[2]), .blk3_hoffset(bh[2]), .blk4_voffset(bv[3]), .blk4_hoffset(bh[3]),
    .chk(cif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: phase 0 idle, 1 query, 2 wait, 3 done
  int m_piece, m_rot, m_kick, m_phase, m_cand;
  bit m_ok, m_zero;
  int kicks [$];
  int n_checks = 0, n_pass = 0;

  function automatic logic [4:0] w5(int x);
    logic [31:0] t;
    t = x;
    return t[4:0];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
  endtask

  task automatic model_reset();
    m_piece = 1; m_rot = 0; m_kick = 0; m_phase = 0; m_cand = 0;
    m_ok = 0; m_zero = 1; kicks.delete();
  endtask

  task automatic model_step();
    if (rst) begin model_reset(); return; end
    m_zero = !active;
    if (!active) m_phase = 0;
    else if (load) begin
      m_phase = 0; m_piece = (piece_type == 3'd7) ? 1 : int'(piece_type);
      m_rot = 0; m_kick = 0;
    end else begin
      case (m_phase)
        0: if (rot_req) begin
          m_cand = (m_rot + (rot_dir ? 3 : 1)) % 4;
          if (m_piece == 1) begin m_rot = m_cand; m_ok = 1; m_phase = 3; end
          else begin
            kicks.delete();
            for (int i = 0; i < NK; i++) kicks.push_back(KO[i]);
            m_phase = 1;
          end
        end
        1: if (cif.chk_ready) m_phase = 2;
        2: if (cif.chk_resp_valid) begin
          if (!cif.chk_collide) begin
            m_rot = m_cand; m_kick = m_kick + kicks[0]; m_ok = 1; m_phase = 3;
          end else begin
            void'(kicks.pop_front());
            if (kicks.size() == 0) begin m_ok = 0; m_phase = 3; end
            else m_phase = 1;
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic compare_all();
    int ev, eh;
    chk("rot_busy", busy, m_phase != 0);
    chk("rot_done", done, m_phase == 3);
    chk("rot_ok", ok, (m_phase == 3) && m_ok);
    chk("rotation", rotation, m_rot[1:0]);
    chk("kick_hoffset", kick, w5(m_kick));
    chk("chk_valid", cif.chk_valid, m_phase == 1);
    chk("chk_rot", cif.chk_rot, (m_phase == 1) ? m_cand[1:0] : 2'd0);
    chk("chk_kick", cif.chk_kick, (m_phase == 1) ? w5(m_kick + kicks[0]) : 5'd0);
    for (int b = 0; b < 4; b++) begin
      if (m_zero) begin ev = 0; eh = 0; end
      else if (b == 0) begin ev = 0; eh = m_kick; end
      else if (m_piece == 2) begin ev = T_V[m_rot][b]; eh = T_H[m_rot][b] + m_kick; end
      else continue;
      chk($sformatf("blk%0d_v", b + 1), bv[b], w5(ev));
      chk($sformatf("blk%0d_h", b + 1), bh[b], w5(eh));
    end
  endtask

  // Inputs change only after the falling edge, so model and DUT see the same values.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_load(logic [2:0] p);
    load = 1; piece_type = p; tick(); load = 0;
  endtask

  // Issue a request (ready held high) and answer with ncol collisions, then a free slot.
  task automatic run_req(logic dir, int ncol);
    rot_req = 1; rot_dir = dir; tick(); rot_req = 0;
    for (int i = 0; i < 12 && m_phase != 3; i++) begin
      tick();
      cif.chk_resp_valid = 1; cif.chk_collide = (i < ncol); tick();
      cif.chk_resp_valid = 0; cif.chk_collide = 0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; active = 0; load = 0; rot_req = 0; rot_dir = 0; piece_type = 0;
    cif.chk_ready = 0; cif.chk_resp_valid = 0; cif.chk_collide = 0;
    model_reset();
    #1 compare_all();
    tick(); tick();
    chk("lit_reset_rot", rotation, 2'd0);
    chk("lit_reset_valid", cif.chk_valid, 1'b0);
    rst = 0; active = 1; tick();

    // load T
    do_load(3'd2); tick();
    chk("lit_loadT_b2h", bh[1], 5'd1);
    chk("lit_loadT_b3h", bh[2], 5'h1f);
    chk("lit_loadT_b4v", bv[3], 5'd1);

    // CW, no collision
    cif.chk_ready = 1;
    rot_req = 1; rot_dir = 0; tick(); rot_req = 0;
    chk("lit_cw_chkrot", cif.chk_rot, 2'd1);
    tick();
    cif.chk_resp_valid = 1; cif.chk_collide = 0; tick(); cif.chk_resp_valid = 0;
    chk("lit_cw_ok", ok, 1'b1);
    chk("lit_cw_b4v", bv[3], 5'd0);
    chk("lit_cw_b4h", bh[3], 5'd1);
    tick();

    // CCW from rot0 with collisions 1,1,0
    do_load(3'd2);
    run_req(1'b1, 2);
`ifdef TETRON_WALL_KICK_EN
    chk("lit_ccw_kick", kick, 5'h1f);
    chk("lit_ccw_b2h", bh[1], 5'h1f);
    chk("lit_ccw_rot", rotation, 2'd3);
`else
    chk("lit_ccw_fail", ok, 1'b0);
    chk("lit_ccw_rot", rotation, 2'd0);
`endif
    tick();

    // every candidate blocked
    do_load(3'd2);
    run_req(1'b0, 99);
    chk("lit_all_done", done, 1'b1);
    chk("lit_all_ok", ok, 1'b0);
    chk("lit_all_rot", rotation, 2'd0);
    tick();

    // four CW steps wrap 3 -> 0
    for (int i = 0; i < 4; i++) begin run_req(1'b0, 0); tick(); end
    chk("lit_wrap_rot", rotation, 2'd0);

    // O and code 7 rotate with no query
    do_load(3'd1);
    run_req(1'b0, 0);
    chk("lit_O_ok", ok, 1'b1);
    chk("lit_O_rot", rotation, 2'd1);
    tick();
    do_load(3'd7);
    run_req(1'b1, 0);
    chk("lit_X_rot", rotation, 2'd3);
    tick();

    // other shapes: pivot and rotation bookkeeping
    for (int p = 0; p < 7; p++) begin
      do_load(3'(p)); run_req(1'b0, 0); tick(); run_req(1'b1, 1); tick();
    end

    // ready stall; requests while busy are dropped
    do_load(3'd2);
    cif.chk_ready = 0;
    rot_req = 1; rot_dir = 0; tick();
    rot_dir = 1;
    for (int i = 0; i < 3; i++) tick();
    rot_req = 0;
    chk("lit_stall_rot", cif.chk_rot, 2'd1);
    chk("lit_stall_kick", cif.chk_kick, 5'd0);
    cif.chk_ready = 1; tick();
    cif.chk_resp_valid = 1; tick(); cif.chk_resp_valid = 0;
    chk("lit_stall_commit", rotation, 2'd1);
    tick();

    // load during WAIT aborts; stray responses ignored
    rot_req = 1; rot_dir = 0; tick(); rot_req = 0; tick();
    do_load(3'd2);
    chk("lit_abort_busy", busy, 1'b0);
    cif.chk_resp_valid = 1; tick(); cif.chk_resp_valid = 0;
    tick(); tick();
    chk("lit_abort_rot", rotation, 2'd0);

    // active low zeroes the offsets and aborts
    rot_req = 1; tick(); rot_req = 0;
    active = 0; tick();
    chk("lit_inactive_b2h", bh[1], 5'd0);
    active = 1; tick(); tick();

    // reset mid-QUERY
    cif.chk_ready = 0;
    rot_req = 1; tick(); rot_req = 0;
    rst = 1; model_reset();
    #1 compare_all();
    chk("lit_rst_valid", cif.chk_valid, 1'b0);
    tick();
    rst = 0; cif.chk_ready = 1; tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
